hazard_unit: RTL and testbench



---
 rtl/pipe_pkg.sv | 22 ++
 rtl/hazard_unit_sat_counter.sv | 31 +++
 rtl/hazard_unit.sv | 141 ++++++++++++++
 tb/tb_hazard_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types: register index, hazard-controller state, NOP encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

  // Architectural register index (8 general-purpose registers).
  typedef logic [2:0] reg_idx_t;

  // Hazard-controller state.
  typedef enum logic {
    RUN      = 1'b0,
    RET_WAIT = 1'b1
  } hazard_state_t;

  // Width of the RET/RTI wait down-counter.
  localparam int unsigned WAIT_W = 4;

  // Instruction word loaded by the pipeline registers when a flush is asserted.
  localparam int unsigned INSTR_W   = 16;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

endpackage : pipe_pkg

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
// Latency: count visible one cycle after the enabling cycle.
// Backpressure: none; clr has priority over en.
//
// Ports:
//   clk  - clock, rising edge
//   clr  - synchronous clear (wins over en)
//   en   - count this cycle
//   cnt  - current count
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic at_max;

  assign at_max = &cnt;

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (en && !at_max) begin
      cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule : sat_counter

// File: rtl/hazard_unit.sv
// Decode-stage stall/flush controller: load-use bubble, taken-branch flush, RET/RTI return wait.
// Latency: zero; controls are combinational from state and this cycle's inputs.
// Backpressure: freezes PC and IF/ID (pc_en/if_id_en low) and injects ID/EX bubbles.
//
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   id_src/id_dst             - register operands of the ID instruction
//   id_uses_src/id_uses_dst   - ID instruction actually reads that operand
//   id_is_ret                 - ID instruction is RET or RTI
//   ex_mem_read/ex_wb/ex_dst  - EX instruction is a load / writes back / its destination
//   branch_taken              - taken branch or jump resolved in EX
//   pc_en, if_id_en           - PC and IF/ID load enables
//   if_id_flush, id_ex_flush  - load NOP into IF/ID, ID/EX
//   busy                      - waiting for the return PC (RET_WAIT)
//   stall_cnt                 - saturating count of cycles with pc_en low
module hazard_unit
  import pipe_pkg::*;
#(
  parameter int unsigned RET_BUBBLES = 3,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  reg_idx_t         id_src,
  input  reg_idx_t         id_dst,
  input  logic             id_uses_src,
  input  logic             id_uses_dst,
  input  logic             id_is_ret,
  input  logic             ex_mem_read,
  input  logic             ex_wb,
  input  reg_idx_t         ex_dst,
  input  logic             branch_taken,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt
);

  // The wait counter is 4 bits, so RET_BUBBLES must lie in 1..15.
  if ((RET_BUBBLES < 1) || (RET_BUBBLES > 15)) begin : g_bad_ret_bubbles
    $error("hazard_unit: RET_BUBBLES must be in 1..15");
  end

  // Loaded on RET entry; the RET_WAIT cycle that sees zero releases the PC.
  localparam logic [WAIT_W-1:0] RET_WAIT_INIT = WAIT_W'(RET_BUBBLES - 1);

  hazard_state_t     state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              lu;
  logic              src_hit;
  logic              dst_hit;

  // Load-use: a load in EX writes a register the ID instruction reads.
  // The load data arrives too late to forward, so ID must wait one cycle.
  assign src_hit = id_uses_src && (id_src == ex_dst);
  assign dst_hit = id_uses_dst && (id_dst == ex_dst);
  assign lu      = ex_mem_read && ex_wb && (src_hit || dst_hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    busy        = 1'b0;

    if (rst) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_d     = RUN;
      wait_cnt_d  = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (branch_taken) begin
            // ID and IF hold wrong-path instructions; a load-use or RET there is moot.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (lu) begin
            // Hold PC and IF/ID, send a bubble to EX. Next cycle EX holds the
            // bubble, so lu drops by itself: exactly one bubble per hazard.
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end else if (id_is_ret) begin
            // RET advances into EX; the fetch behind it is wrong-path and dropped.
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
            state_d     = RET_WAIT;
            wait_cnt_d  = RET_WAIT_INIT;
          end
        end

        RET_WAIT: begin
          // Only bubbles sit behind the RET, so branch/lu/ret inputs are ignored.
          busy        = 1'b1;
          if_id_flush = 1'b1;
          if (wait_cnt_q == '0) begin
            // Return address is ready; PC mux loads it this cycle.
            pc_en   = 1'b1;
            state_d = RUN;
          end else begin
            pc_en      = 1'b0;
            wait_cnt_d = wait_cnt_q - 1'b1;
          end
        end

        default: begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      endcase
    end
  end

  // Reset cycles hold pc_en low too but are not counted: clr wins over en.
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .en  (!pc_en),
    .cnt (stall_cnt)
  );

endmodule : hazard_unit

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit: single-cycle vector table plus
// load-use, RET wait, reset-during-RET and counter saturation sequences.
module tb_hazard_unit;

  logic       clk;
  logic       rst;
  logic [2:0] id_src;
  logic [2:0] id_dst;
  logic       id_uses_src;
  logic       id_uses_dst;
  logic       id_is_ret;
  logic       ex_mem_read;
  logic       ex_wb;
  logic [2:0] ex_dst;
  logic       branch_taken;

  logic        pc_en, if_id_en, if_id_flush, id_ex_flush, busy;
  logic [15:0] stall_cnt;
  logic        s_pc_en, s_if_id_en, s_if_id_flush, s_id_ex_flush, s_busy;
  logic [3:0]  s_stall_cnt;

  int tests;
  int failed;
  int exp_cnt;

  hazard_unit #(.RET_BUBBLES(3), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .id_src(id_src), .id_dst(id_dst),
    .id_uses_src(id_uses_src), .id_uses_dst(id_uses_dst),
    .id_is_ret(id_is_ret),
    .ex_mem_read(ex_mem_read), .ex_wb(ex_wb), .ex_dst(ex_dst),
    .branch_taken(branch_taken),
    .pc_en(pc_en), .if_id_en(if_id_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .busy(busy), .stall_cnt(stall_cnt)
  );

  // Narrow-counter instance for the saturation check.
  hazard_unit #(.RET_BUBBLES(3), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst),
    .id_src(id_src), .id_dst(id_dst),
    .id_uses_src(id_uses_src), .id_uses_dst(id_uses_dst),
    .id_is_ret(id_is_ret),
    .ex_mem_read(ex_mem_read), .ex_wb(ex_wb), .ex_dst(ex_dst),
    .branch_taken(branch_taken),
    .pc_en(s_pc_en), .if_id_en(s_if_id_en),
    .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
    .busy(s_busy), .stall_cnt(s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] src;
    logic [2:0] dst;
    logic       use_s;
    logic       use_d;
    logic       ret;
    logic       mrd;
    logic       wb;
    logic [2:0] edst;
    logic       br;
    logic       e_pc_en;
    logic       e_if_id_en;
    logic       e_if_flush;
    logic       e_ex_flush;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] src, input logic [2:0] dst, input logic use_s,
                       input logic use_d, input logic ret, input logic mrd, input logic wb,
                       input logic [2:0] edst, input logic br);
    id_src       = src;
    id_dst       = dst;
    id_uses_src  = use_s;
    id_uses_dst  = use_d;
    id_is_ret    = ret;
    ex_mem_read  = mrd;
    ex_wb        = wb;
    ex_dst       = edst;
    branch_taken = br;
  endtask

  task automatic idle();
    drive(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic check_ctl(input string name, input logic e_pc, input logic e_ifen,
                           input logic e_iff, input logic e_exf, input logic e_busy);
    check({name, ".pc_en"},       {31'd0, pc_en},       {31'd0, e_pc});
    check({name, ".if_id_en"},    {31'd0, if_id_en},    {31'd0, e_ifen});
    check({name, ".if_id_flush"}, {31'd0, if_id_flush}, {31'd0, e_iff});
    check({name, ".id_ex_flush"}, {31'd0, id_ex_flush}, {31'd0, e_exf});
    check({name, ".busy"},        {31'd0, busy},        {31'd0, e_busy});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests   = 0;
    failed  = 0;
    exp_cnt = 0;

    //          name         src   dst  us  ud  ret mrd wb  edst  br   pc ife iff exf
    vecs[0] = '{"idle",      3'd0, 3'd0, 0, 0, 0,  0,  0, 3'd0, 0,   1, 1, 0, 0};
    vecs[1] = '{"lu_src",    3'd3, 3'd1, 1, 0, 0,  1,  1, 3'd3, 0,   0, 0, 0, 1};
    vecs[2] = '{"nouse_src", 3'd3, 3'd1, 0, 0, 0,  1,  1, 3'd3, 0,   1, 1, 0, 0};
    vecs[3] = '{"no_wb",     3'd3, 3'd1, 1, 0, 0,  1,  0, 3'd3, 0,   1, 1, 0, 0};
    vecs[4] = '{"lu_dst",    3'd2, 3'd5, 0, 1, 0,  1,  1, 3'd5, 0,   0, 0, 0, 1};
    vecs[5] = '{"not_load",  3'd2, 3'd5, 0, 1, 0,  0,  1, 3'd5, 0,   1, 1, 0, 0};
    vecs[6] = '{"reg_diff",  3'd3, 3'd4, 1, 1, 0,  1,  1, 3'd2, 0,   1, 1, 0, 0};
    vecs[7] = '{"br_prio",   3'd3, 3'd1, 1, 0, 1,  1,  1, 3'd3, 1,   1, 1, 1, 1};
    vecs[8] = '{"br_only",   3'd0, 3'd0, 0, 0, 0,  0,  0, 3'd0, 1,   1, 1, 1, 1};

    // Reset: outputs forced while rst is high.
    rst = 1'b1;
    idle();
    #1;
    check_ctl("reset", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    check("reset.stall_cnt", {16'd0, stall_cnt}, 32'd0);
    rst = 1'b0;

    // Single-cycle vectors, all taken from RUN.
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].src, vecs[i].dst, vecs[i].use_s, vecs[i].use_d, vecs[i].ret,
            vecs[i].mrd, vecs[i].wb, vecs[i].edst, vecs[i].br);
      #1;
      check_ctl(vecs[i].name, vecs[i].e_pc_en, vecs[i].e_if_id_en,
                vecs[i].e_if_flush, vecs[i].e_ex_flush, 1'b0);
      if (!vecs[i].e_pc_en) exp_cnt++;
      tick();
      check({vecs[i].name, ".stall_cnt"}, {16'd0, stall_cnt}, exp_cnt);
      check({vecs[i].name, ".busy_after"}, {31'd0, busy}, 32'd0);
    end

    // Load-use then bubble in EX: exactly one stall cycle.
    drive(3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0);
    #1;
    check_ctl("lu_seq0", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_cnt++;
    tick();
    drive(3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    #1;
    check_ctl("lu_seq1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("lu_seq.stall_cnt", {16'd0, stall_cnt}, exp_cnt);

    // RET with RET_BUBBLES=3: entry, then three RET_WAIT cycles with pc_en 0,0,1.
    idle();
    id_is_ret = 1'b1;
    #1;
    check_ctl("ret_entry", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_cnt++;
    tick();
    // Branch, load-use and another RET are all ignored while waiting.
    drive(3'd3, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 1'b1);
    #1;
    check_ctl("ret_w0", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    exp_cnt++;
    tick();
    idle();
    #1;
    check_ctl("ret_w1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    exp_cnt++;
    tick();
    check_ctl("ret_w2", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    check_ctl("ret_done", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("ret.stall_cnt", {16'd0, stall_cnt}, exp_cnt);
    tick();
    check("ret.busy_stays_low", {31'd0, busy}, 32'd0);

    // Reset asserted on the second RET_WAIT cycle.
    id_is_ret = 1'b1;
    #1;
    tick();
    idle();
    tick();
    check("rret.busy_w1", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check_ctl("rret_rst", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    check_ctl("rret_after", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("rret.stall_cnt", {16'd0, stall_cnt}, 32'd0);
    check("rret.sat_cnt", {28'd0, s_stall_cnt}, 32'd0);
    exp_cnt = 0;
    tick();
    check("rret.busy_later", {31'd0, busy}, 32'd0);

    // Saturation: hold a load-use condition for 20 cycles.
    drive(3'd6, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd6, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 14) check("sat.cnt14", {28'd0, s_stall_cnt}, 32'd14);
    end
    check("sat.cnt_held", {28'd0, s_stall_cnt}, 32'd15);
    check("sat.wide_cnt", {16'd0, stall_cnt}, 32'd20);
    idle();
    #1;
    check("sat.pc_en_release", {31'd0, s_pc_en}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_hazard_unit
